// File: rtl/gerador_ajuste.sv
// gerador_ajuste
//   Converts the raw "+" / "-" front-panel buttons into one-cycle acrescer /
//   decrecer strobes for the setpoint counter. Each button passes through a
//   2-FF synchroniser and a debouncer. A small FSM then detects presses and
//   blocks both strobes while the two buttons are held together.
//
//   Optional feature, selected by the macro AUTO_REPEAT_EN:
//     defined   - a held button re-strobes REPEAT_DELAY cycles after the
//                 first strobe, then every REPEAT_PERIOD cycles. repetindo
//                 is high while repeating.
//     undefined - exactly one strobe per press. repetindo is tied 0 and the
//                 repeat timer does not exist.
//
// Ports
//   clk, rst_n           clock and asynchronous active-low reset
//   btn_mais, btn_menos  raw buttons, active-high, asynchronous to clk
//   acrescer, decrecer   registered one-cycle strobes, never high together
//   repetindo            registered auto-repeat indicator
module gerador_ajuste #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_DELAY    = 20,
   parameter int REPEAT_PERIOD   = 5,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_mais,
   input  logic btn_menos,
   output logic acrescer,
   output logic decrecer,
   output logic repetindo
);

   typedef enum logic [1:0] {OCIOSO, SEG_MAIS, SEG_MENOS, BLOQUEADO} estado_t;

   // Bit 0 carries the "+" button and bit 1 carries the "-" button.
   logic [1:0]            sync1_q, sync2_q;
   logic [1:0]            deb_q, deb_d;
   logic [1:0][CNT_W-1:0] dcnt_q, dcnt_d;
   estado_t               est_q, est_d;
   logic                  acr_q, acr_d, dec_q, dec_d;
   logic                  m, n;

`ifdef AUTO_REPEAT_EN
   logic [CNT_W-1:0]      tmr_q, tmr_d;
   logic                  rep_q, rep_d;
   logic                  tick;
`endif

   // Debounce. The counter tracks consecutive samples that disagree with the
   // debounced state. Any sample that agrees clears the counter.
   always_comb begin
      deb_d  = deb_q;
      dcnt_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (dcnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1))
               deb_d[i] = sync2_q[i];
            else
               dcnt_d[i] = dcnt_q[i] + 1'b1;
         end
      end
   end

   assign m = deb_q[0];
   assign n = deb_q[1];

`ifdef AUTO_REPEAT_EN
   // After the first repeat strobe, rep_q switches the timer's target
   // interval from REPEAT_DELAY to REPEAT_PERIOD.
   assign tick = rep_q ? (tmr_q == CNT_W'(REPEAT_PERIOD - 1))
                       : (tmr_q == CNT_W'(REPEAT_DELAY - 1));
`endif

   always_comb begin
      est_d = est_q;
      acr_d = 1'b0;
      dec_d = 1'b0;
`ifdef AUTO_REPEAT_EN
      // Outside the SEG_* states the timer stays at 0, so entering SEG_*
      // always starts a fresh count.
      tmr_d = '0;
      rep_d = 1'b0;
`endif
      case (est_q)
         OCIOSO: begin
            if (m && n)
               est_d = BLOQUEADO;
            else if (m) begin
               acr_d = 1'b1;
               est_d = SEG_MAIS;
            end else if (n) begin
               dec_d = 1'b1;
               est_d = SEG_MENOS;
            end
         end
         SEG_MAIS, SEG_MENOS: begin
            // The release check comes first, so a release that lands on a
            // repeat slot produces no strobe.
            if (!((est_q == SEG_MAIS) ? m : n))
               est_d = OCIOSO;
            else if ((est_q == SEG_MAIS) ? n : m)
               est_d = BLOQUEADO;
`ifdef AUTO_REPEAT_EN
            else begin
               rep_d = rep_q;
               if (tick) begin
                  acr_d = (est_q == SEG_MAIS);
                  dec_d = (est_q == SEG_MENOS);
                  rep_d = 1'b1;
               end else if (tmr_q != '1)
                  tmr_d = tmr_q + 1'b1;  // saturate instead of wrapping
               else
                  tmr_d = tmr_q;
            end
`endif
         end
         BLOQUEADO: begin
            if (!m && !n)
               est_d = OCIOSO;
         end
         default: est_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         dcnt_q  <= '0;
         est_q   <= OCIOSO;
         acr_q   <= 1'b0;
         dec_q   <= 1'b0;
`ifdef AUTO_REPEAT_EN
         tmr_q   <= '0;
         rep_q   <= 1'b0;
`endif
      end else begin
         sync1_q <= {btn_menos, btn_mais};
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         dcnt_q  <= dcnt_d;
         est_q   <= est_d;
         acr_q   <= acr_d;
         dec_q   <= dec_d;
`ifdef AUTO_REPEAT_EN
         tmr_q   <= tmr_d;
         rep_q   <= rep_d;
`endif
      end
   end

   assign acrescer = acr_q;
   assign decrecer = dec_q;
`ifdef AUTO_REPEAT_EN
   assign repetindo = rep_q;
`else
   assign repetindo = 1'b0;
`endif

endmodule

// File: tb/tb_gerador_ajuste.sv
// tb_gerador_ajuste
//   Scoreboard bench for gerador_ajuste. Each scenario pushes the expected
//   strobes (cycle, kind) onto a queue when it drives the buttons. A negedge
//   monitor pops one entry for every strobe cycle the DUT produces. The
//   posedge counter cyc numbers the edges, so a strobe registered on edge k
//   is seen by the monitor with cyc == k.
module tb_gerador_ajuste;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic btn_mais = 1'b0;
   logic btn_menos = 1'b0;
   logic acrescer, decrecer, repetindo;

   gerador_ajuste dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_mais  (btn_mais),
      .btn_menos (btn_menos),
      .acrescer  (acrescer),
      .decrecer  (decrecer),
      .repetindo (repetindo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   localparam int ACR = 1;
   localparam int DEC = 2;
   typedef struct {int cyc; int kind;} ev_t;
   ev_t exp_q[$];

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push(input int c, input int k);
      ev_t e;
      e.cyc  = c;
      e.kind = k;
      exp_q.push_back(e);
   endtask

   task automatic at_edge(input int e);
      while (cyc < e) @(negedge clk);
   endtask

   task automatic drained(input string tag);
      check(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Strobe monitor. A strobe two cycles wide would pop a second entry and
   // be flagged as unexpected or mistimed.
   ev_t ev;
   always @(negedge clk) begin
      if (rst_n && (acrescer || decrecer)) begin
         check("exclusivo", int'(acrescer && decrecer), 0);
         if (exp_q.size() == 0)
            check("strobe_inesperado", cyc, -1);
         else begin
            ev = exp_q.pop_front();
            check("strobe_ciclo", cyc, ev.cyc);
            check("strobe_tipo", acrescer ? ACR : DEC, ev.kind);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
      $fatal(1);
   end

   int e0;

   initial begin
      // reset state
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_acrescer", int'(acrescer), 0);
      check("rst_decrecer", int'(decrecer), 0);
      check("rst_repetindo", int'(repetindo), 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // 1: "+" sampled high on edges 0-9 gives one acrescer after edge 6
      e0 = cyc + 1;
      btn_mais = 1'b1;
      push(e0 + 6, ACR);
      at_edge(e0 + 9);
      btn_mais = 1'b0;
      repeat (20) @(negedge clk);
      drained("t1_fila");

      // 2: a 3-cycle glitch and a 1-cycle glitch on "-" produce no strobe
      btn_menos = 1'b1;
      repeat (3) @(negedge clk);
      btn_menos = 1'b0;
      repeat (2) @(negedge clk);
      btn_menos = 1'b1;
      @(negedge clk);
      btn_menos = 1'b0;
      repeat (20) @(negedge clk);
      drained("t2_fila");

      // 3: "+" held on edges 0-37
      e0 = cyc + 1;
      btn_mais = 1'b1;
      push(e0 + 6, ACR);
`ifdef AUTO_REPEAT_EN
      push(e0 + 26, ACR);
      push(e0 + 31, ACR);
      push(e0 + 36, ACR);
      push(e0 + 41, ACR);
      at_edge(e0 + 25);
      check("t3_rep_antes", int'(repetindo), 0);
      at_edge(e0 + 26);
      check("t3_rep_inicio", int'(repetindo), 1);
      at_edge(e0 + 37);
      check("t3_rep_meio", int'(repetindo), 1);
`else
      at_edge(e0 + 26);
      check("t3_rep_off", int'(repetindo), 0);
`endif
      at_edge(e0 + 37);
      btn_mais = 1'b0;
      at_edge(e0 + 50);
      check("t3_rep_fim", int'(repetindo), 0);
      repeat (10) @(negedge clk);
      drained("t3_fila");

      // 4: both buttons pressed together are blocked; a later "-" press works
      btn_mais  = 1'b1;
      btn_menos = 1'b1;
      repeat (12) @(negedge clk);
      btn_mais  = 1'b0;
      btn_menos = 1'b0;
      repeat (15) @(negedge clk);
      drained("t4_bloq");
      e0 = cyc + 1;
      btn_menos = 1'b1;
      push(e0 + 6, DEC);
      at_edge(e0 + 9);
      btn_menos = 1'b0;
      repeat (20) @(negedge clk);
      drained("t4_fila");

      // 5: "+" held with "-" added on edge 10; the repeat is suppressed and
      //    the FSM returns to idle once both are released
      e0 = cyc + 1;
      btn_mais = 1'b1;
      push(e0 + 6, ACR);
      at_edge(e0 + 9);
      btn_menos = 1'b1;
      at_edge(e0 + 40);
      check("t5_rep", int'(repetindo), 0);
      btn_mais  = 1'b0;
      btn_menos = 1'b0;
      repeat (20) @(negedge clk);
      drained("t5_bloq");
      e0 = cyc + 1;
      btn_menos = 1'b1;
      push(e0 + 6, DEC);
      at_edge(e0 + 9);
      btn_menos = 1'b0;
      repeat (20) @(negedge clk);
      drained("t5_ocioso");

      // 6: reset during a hold; the still-held button is a new press
      e0 = cyc + 1;
      btn_mais = 1'b1;
      push(e0 + 6, ACR);
      at_edge(e0 + 14);
      rst_n = 1'b0;
      #1;
      check("t6_rst_acrescer", int'(acrescer), 0);
      check("t6_rst_decrecer", int'(decrecer), 0);
      check("t6_rst_repetindo", int'(repetindo), 0);
      drained("t6_antes");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      e0 = cyc + 1;
      push(e0 + 6, ACR);
      at_edge(e0 + 12);
      btn_mais = 1'b0;
      repeat (20) @(negedge clk);
      drained("t6_fila");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
